// File: rtl/riscv_fetch_control.sv
// -----------------------------------------------------------------------------
// riscv_fetch_control
//
// Instruction-fetch sequencer for the RISC-V core. Owns the PC, issues one
// outstanding request at a time to instruction memory (req/gnt/rvalid), holds
// each fetched instruction for decode until it is consumed, and applies
// redirects from branch resolution. A fetch that is already in flight when a
// redirect arrives is marked stale and its response is dropped.
//
// Parameters:
//   RESET_PC        fetch address after reset
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   imem_req_o      fetch request valid
//   imem_addr_o     fetch address (word aligned)
//   imem_gnt_i      memory accepted the request this cycle
//   imem_rvalid_i   response data valid
//   imem_rdata_i    response instruction word
//   instr_valid_o   instr_o / instr_pc_o hold a valid instruction
//   instr_o         fetched instruction
//   instr_pc_o      PC of instr_o
//   stall_i         downstream cannot consume this cycle
//   redirect_i      taken branch/jump, fetch continues at redirect_pc_i
//   redirect_pc_i   redirect target
//   misaligned_o    one-cycle pulse: redirect target had bits [1:0] != 0
// -----------------------------------------------------------------------------
module riscv_fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        stall_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request driven, waiting for gnt
        S_WAIT = 2'd1,  // request accepted, waiting for rvalid
        S_HOLD = 2'd2   // instruction presented, waiting for consumption
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic        kill_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        misaligned_q;

    // Redirect targets are forced to a word boundary; the dropped low bits
    // are only reported through misaligned_o.
    logic [31:0] target;
    logic        target_misaligned;

    assign target            = {redirect_pc_i[31:2], 2'b00};
    assign target_misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values present before the edge; a blocking assignment
    // here would let later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the instruction/PC datapath registers are reset as well,
            // so decode never sees stale data on instr_o after reset.
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            kill_q       <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0;
            instr_pc_q   <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= target_misaligned;

            case (state_q)
                S_REQ: begin
                    // req_q is low only in the first cycle after reset; a gnt
                    // is meaningful only while the request is actually driven.
                    if (req_q && imem_gnt_i) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                        if (redirect_i) begin
                            // The accepted fetch is now stale.
                            pc_q   <= target;
                            kill_q <= 1'b1;
                        end
                    end else begin
                        req_q <= 1'b1;
                        if (redirect_i) begin
                            // Not yet granted: retarget the pending request.
                            pc_q   <= target;
                            addr_q <= target;
                        end
                    end
                end

                S_WAIT: begin
                    if (redirect_i) begin
                        pc_q <= target;
                        if (imem_rvalid_i) begin
                            // Arriving response is stale; fetch target now.
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            addr_q  <= target;
                            kill_q  <= 1'b0;
                        end else begin
                            kill_q <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        if (kill_q) begin
                            // pc_q already holds the redirect target.
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                        end else begin
                            state_q    <= S_HOLD;
                            valid_q    <= 1'b1;
                            instr_q    <= imem_rdata_i;
                            instr_pc_q <= pc_q;
                        end
                    end
                end

                S_HOLD: begin
                    // A redirect drops the held instruction even when stalled.
                    if (redirect_i) begin
                        state_q <= S_REQ;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        pc_q    <= target;
                        addr_q  <= target;
                    end else if (!stall_i) begin
                        // Sequential fetch; wraps silently at the top of memory.
                        state_q <= S_REQ;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        pc_q    <= instr_pc_q + 32'd4;
                        addr_q  <= instr_pc_q + 32'd4;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                    valid_q <= 1'b0;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_riscv_fetch_control.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_control
//
// Cycle-stepped bench for riscv_fetch_control. Each vector gives the inputs
// for one clock edge and the outputs expected just after it. Instructions the
// fetch unit is expected to deliver are queued when their response is driven
// and popped when instr_valid_o rises; killed responses are never queued.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_control;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        misaligned_o;

    riscv_fetch_control #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .misaligned_o  (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t cur;
    logic prev_valid;
    int   n_checks;
    int   n_fail;
    int   step_no;

    function automatic vec_t mk(
        input logic rst, input logic gnt, input logic rvalid, input logic [31:0] rdata,
        input logic stall, input logic redir, input logic [31:0] rpc,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.rst = rst;     v.gnt = gnt;       v.rvalid = rvalid; v.rdata = rdata;
        v.stall = stall; v.redir = redir;   v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc;   v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", step_no, name, act, exp);
        end
    endtask

    // Drive one edge's worth of inputs, then compare outputs 1 time unit
    // after that edge.
    task automatic apply(input vec_t v);
        exp_t e;
        reset         = v.rst;
        imem_gnt_i    = v.gnt;
        imem_rvalid_i = v.rvalid;
        imem_rdata_i  = v.rdata;
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        if (v.rvalid && v.e_valid && !v.rst) begin
            e.pc    = v.e_pc;
            e.instr = v.rdata;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("imem_req_o", {31'h0, imem_req_o}, {31'h0, v.e_req});
        if (v.e_req || v.rst)
            check("imem_addr_o", imem_addr_o, v.e_addr);
        check("instr_valid_o", {31'h0, instr_valid_o}, {31'h0, v.e_valid});
        check("misaligned_o", {31'h0, misaligned_o}, {31'h0, v.e_mis});
        if (v.rst) begin
            check("instr_o_reset", instr_o, 32'h0);
            check("instr_pc_o_reset", instr_pc_o, 32'h0);
        end
        if (instr_valid_o && !prev_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL step %0d scoreboard: unexpected instruction 0x%08h at pc 0x%08h, none expected",
                         step_no, instr_o, instr_pc_o);
            end else begin
                cur = sb.pop_front();
            end
        end
        if (instr_valid_o) begin
            check("instr_o", instr_o, cur.instr);
            check("instr_pc_o", instr_pc_o, cur.pc);
        end
        prev_valid = instr_valid_o;
        step_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        step_no       = 0;
        prev_valid    = 1'b0;
        cur.pc        = 32'h0;
        cur.instr     = 32'h0;
        reset         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;

        // Fields: rst gnt rvalid rdata stall redir rpc | req addr valid pc mis
        // Reset, then back-to-back fetches of 0x0, 0x4, 0x8.
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h8,   0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'hC,   0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h00100093, 0, 0, 32'h0,   0, 32'h0,   1, 32'hC,   0));
        // Four stalled cycles in HOLD: nothing moves, no request.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 32'h0,   1, 32'hC,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h10,  0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0));
        // Consumption together with a redirect to 0x100.
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h100, 1, 32'h100, 0, 32'h0,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 1, 32'h00000517, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Fetch 0x10 then 0x14; redirect to 0x200 while 0x14 is in flight,
        // its response (0xDEADBEEF) arrives two cycles later and is dropped.
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'h10,  1, 32'h10,  0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0));
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h14,  0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'h200, 0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0,   0));

        // Redirect to 0x300 before gnt: address changes, req held high.
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'h300, 1, 32'h300, 0, 32'h0,   0));
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h30000013, 0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0));

        // Misaligned target 0x402: one-cycle pulse, fetch at 0x400.
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'h402, 1, 32'h400, 0, 32'h0,   1));
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h400, 0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h40000013, 0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0));

        // PC wrap: 0xFFFF_FFFC consumed -> next fetch at 0x0.
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0, 0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'hFFF00013, 0, 0, 32'h0,   0, 32'h0,   1, 32'hFFFFFFFC, 0));
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0));

        // Redirect in the same cycle as gnt: the granted fetch is killed.
        apply(mk(0, 1, 0, 32'h0,        0, 1, 32'h500, 0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h0BAD0BAD, 0, 0, 32'h0,   1, 32'h500, 0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h50000013, 0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0));

        // Redirect while stalled in HOLD drops the instruction.
        apply(mk(0, 0, 0, 32'h0,        1, 1, 32'h600, 1, 32'h600, 0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));

        // Reset while in WAIT; the outstanding response after reset is ignored.
        apply(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h0BAD0BAD, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h13,       0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0));

        // Redirect in WAIT coinciding with rvalid: response dropped at once.
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h0BAD0BAD, 0, 1, 32'h700, 1, 32'h700, 0, 32'h0,   0));

        // Two redirects during WAIT: the last one wins (first is misaligned).
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'h803, 0, 32'h0,   0, 32'h0,   1));
        apply(mk(0, 0, 0, 32'h0,        0, 1, 32'h900, 0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h0BAD0BAD, 0, 0, 32'h0,   1, 32'h900, 0, 32'h0,   0));
        apply(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0));
        apply(mk(0, 0, 1, 32'h90000013, 0, 0, 32'h0,   0, 32'h0,   1, 32'h900, 0));
        apply(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h904, 0, 32'h0,   0));

        // Every queued instruction must have been delivered.
        check("scoreboard_left", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
